// File: rtl/kmeans_pkg.sv
// Shared k-means types: assignment-buffer opcodes, FSM states and a word-count helper.
package kmeans_pkg;

    typedef enum logic [1:0] {
        OP_LOAD    = 2'd0,
        OP_STORE   = 2'd1,
        OP_COMPARE = 2'd2,
        OP_RSVD    = 2'd3
    } assign_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_WRITE = 2'd3
    } assign_buf_state_e;

    // 33-bit arithmetic so num close to 2^32 cannot overflow the rounding add
    function automatic logic [32:0] ceil_div(input logic [32:0] num, input logic [32:0] den);
        return (num + den - 33'd1) / den;
    endfunction

endpackage

// File: rtl/assign_lane_cmp.sv
// Combinational lane comparator: counts valid lanes where two packed words differ.
module assign_lane_cmp #(
    parameter int WORD_W       = 32,
    parameter int PTS_PER_WORD = 4
) (
    input  logic [WORD_W-1:0]                     a_i,
    input  logic [WORD_W-1:0]                     b_i,
    input  logic [PTS_PER_WORD-1:0]               valid_i,
    output logic [$clog2(PTS_PER_WORD+1)-1:0]     count_o
);

    localparam int LANE_W = WORD_W / PTS_PER_WORD;
    localparam int CW     = $clog2(PTS_PER_WORD + 1);

    always_comb begin
        count_o = '0;
        for (int l = 0; l < PTS_PER_WORD; l++) begin
            if (valid_i[l] && (a_i[l*LANE_W +: LANE_W] != b_i[l*LANE_W +: LANE_W])) begin
                count_o = count_o + CW'(1);
            end
        end
    end

endmodule

// File: rtl/assignment_array_buffer.sv
// Snapshot buffer for the k-means assignment array: LOAD, STORE and (with
// ASSIGN_BUF_CMP_EN defined) COMPARE against the live IO BRAM contents.
module assignment_array_buffer
    import kmeans_pkg::*;
#(
    parameter int WORD_W       = 32,
    parameter int PTS_PER_WORD = 4,
    parameter int MAX_POINTS   = 4096,
    parameter int ADDR_W       = 15,
    parameter int BASE_ADDR    = 0
) (
    input  logic                              clk_i,
    input  logic                              reset_ni,
    input  logic                              start_i,
    input  logic [1:0]                        op_i,
    input  logic [31:0]                       num_vals_i,
    output logic                              ready_o,
    output logic                              done_o,
    output logic                              err_o,
    output logic                              buf_valid_o,
    output logic [$clog2(MAX_POINTS+1)-1:0]   changed_o,
    output logic                              converged_o,
    output logic [ADDR_W-1:0]                 io_addr_o,
    input  logic [WORD_W-1:0]                 io_din_i,
    output logic [WORD_W-1:0]                 io_dout_o,
    output logic                              io_we_o
);

    localparam int DEPTH = MAX_POINTS / PTS_PER_WORD;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NW_W  = $clog2(DEPTH + 1);

    assign_buf_state_e state;
    assign_op_e        op_req;
    assign_op_e        op_q;
    logic [NW_W-1:0]   n_words;
    logic [IDX_W-1:0]  addr_cnt;
    logic [IDX_W-1:0]  cap_idx;
    logic              cap_valid;
    logic [WORD_W-1:0] buf_mem [DEPTH];
    logic [WORD_W-1:0] rd_word;
    logic [IDX_W-1:0]  rd_idx;

    logic [32:0]       words_raw;
    logic [NW_W-1:0]   n_req;
    logic              idle_req, op_bad, need_valid;
    logic              req_bad, req_empty, req_inval, req_go;
    logic              last_word;

    assign op_req    = assign_op_e'(op_i);
    assign words_raw = ceil_div({1'b0, num_vals_i}, 33'(PTS_PER_WORD));
    assign n_req     = (words_raw > 33'(DEPTH)) ? NW_W'(DEPTH) : NW_W'(words_raw);

`ifdef ASSIGN_BUF_CMP_EN
    assign op_bad = (op_req == OP_RSVD);
`else
    assign op_bad = (op_req == OP_RSVD) || (op_req == OP_COMPARE);
`endif

    // Request decode; the empty case wins over the missing-snapshot check
    assign idle_req   = (state == ST_IDLE) && start_i;
    assign need_valid = (op_req != OP_LOAD) && !buf_valid_o;
    assign req_bad    = idle_req && op_bad;
    assign req_empty  = idle_req && !op_bad && (n_req == '0);
    assign req_inval  = idle_req && !op_bad && (n_req != '0) && need_valid;
    assign req_go     = idle_req && !op_bad && (n_req != '0) && !need_valid;

    assign last_word  = (NW_W'(addr_cnt) == n_words - NW_W'(1));

    assign ready_o    = (state == ST_IDLE);
    assign io_we_o    = (state == ST_WRITE);
    assign io_addr_o  = ADDR_W'(BASE_ADDR) + ADDR_W'(addr_cnt);

    // Single read port shared by STORE (current address) and COMPARE (captured index)
    assign rd_idx    = (state == ST_WRITE) ? addr_cnt : cap_idx;
    assign rd_word   = buf_mem[rd_idx];
    assign io_dout_o = (state == ST_WRITE) ? rd_word : '0;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state       <= ST_IDLE;
            op_q        <= OP_LOAD;
            n_words     <= '0;
            addr_cnt    <= '0;
            cap_idx     <= '0;
            cap_valid   <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            buf_valid_o <= 1'b0;
        end else begin
            done_o    <= 1'b0;
            err_o     <= 1'b0;
            cap_valid <= (state == ST_READ);
            cap_idx   <= addr_cnt;
            case (state)
                ST_IDLE: begin
                    if (req_bad || req_inval) begin
                        err_o <= 1'b1;
                    end else if (req_empty) begin
                        done_o <= 1'b1;
                    end else if (req_go) begin
                        op_q     <= op_req;
                        n_words  <= n_req;
                        addr_cnt <= '0;
                        if (op_req == OP_LOAD) begin
                            buf_valid_o <= 1'b0;
                        end
                        state <= (op_req == OP_STORE) ? ST_WRITE : ST_READ;
                    end
                end
                ST_READ: begin
                    if (last_word) begin
                        addr_cnt <= '0;
                        state    <= ST_DRAIN;
                    end else begin
                        addr_cnt <= addr_cnt + IDX_W'(1);
                    end
                end
                ST_DRAIN: begin
                    done_o <= 1'b1;
                    state  <= ST_IDLE;
                    if (op_q == OP_LOAD) begin
                        buf_valid_o <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (last_word) begin
                        addr_cnt <= '0;
                        done_o   <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        addr_cnt <= addr_cnt + IDX_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (cap_valid && (op_q == OP_LOAD)) begin
            buf_mem[cap_idx] <= io_din_i;
        end
    end

`ifdef ASSIGN_BUF_CMP_EN
    localparam int CNT_W = $clog2(MAX_POINTS + 1);
    localparam int LC_W  = $clog2(PTS_PER_WORD + 1);

    logic [PTS_PER_WORD-1:0] mask_req, last_mask, cap_mask;
    logic [31:0]             rem_req;
    logic [LC_W-1:0]         lane_cnt;
    logic [CNT_W-1:0]        cmp_acc, cmp_sum, changed_q;
    logic                    converged_q;

    // Partial last word only when the count was not clamped and leaves a remainder
    always_comb begin
        rem_req  = num_vals_i % 32'(PTS_PER_WORD);
        mask_req = '1;
        if ((num_vals_i <= 32'(MAX_POINTS)) && (rem_req != 32'd0)) begin
            for (int l = 0; l < PTS_PER_WORD; l++) begin
                mask_req[l] = (32'(l) < rem_req);
            end
        end
    end

    assign cap_mask = (NW_W'(cap_idx) == n_words - NW_W'(1)) ? last_mask : '1;
    assign cmp_sum  = cmp_acc + CNT_W'(lane_cnt);

    assign_lane_cmp #(
        .WORD_W       (WORD_W),
        .PTS_PER_WORD (PTS_PER_WORD)
    ) u_lane_cmp (
        .a_i     (io_din_i),
        .b_i     (rd_word),
        .valid_i (cap_mask),
        .count_o (lane_cnt)
    );

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            last_mask   <= '0;
            cmp_acc     <= '0;
            changed_q   <= '0;
            converged_q <= 1'b0;
        end else begin
            if (req_go) begin
                last_mask <= mask_req;
                cmp_acc   <= '0;
            end else if (cap_valid && (op_q == OP_COMPARE)) begin
                cmp_acc <= cmp_sum;
            end
            if (req_empty && (op_req == OP_COMPARE)) begin
                changed_q   <= '0;
                converged_q <= 1'b1;
            end else if ((state == ST_DRAIN) && (op_q == OP_COMPARE)) begin
                changed_q   <= cmp_sum;
                converged_q <= (cmp_sum == '0);
            end
        end
    end

    assign changed_o   = changed_q;
    assign converged_o = converged_q;
`else
    assign changed_o   = '0;
    assign converged_o = 1'b0;
`endif

endmodule

// File: tb/tb_assignment_array_buffer.sv
// Directed self-checking bench for assignment_array_buffer with a 1-cycle-latency BRAM model.
module tb_assignment_array_buffer;

    localparam int BASE = 16;

    logic        clk_i = 1'b0;
    logic        reset_ni = 1'b0;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = 2'd0;
    logic [31:0] num_vals_i = 32'd0;
    logic        ready_o, done_o, err_o, buf_valid_o, converged_o, io_we_o;
    logic [12:0] changed_o;
    logic [14:0] io_addr_o;
    logic [31:0] io_din_i, io_dout_o;

    logic [31:0] mem [0:32767];
    logic        poke_en = 1'b0;
    logic [14:0] poke_addr = '0;
    logic [31:0] poke_data = '0;

    int n_cmp = 0;
    int n_bad = 0;
    int we_cnt = 0;
    int max_addr = 0;

    assignment_array_buffer #(
        .WORD_W(32), .PTS_PER_WORD(4), .MAX_POINTS(4096), .ADDR_W(15), .BASE_ADDR(BASE)
    ) dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .start_i(start_i), .op_i(op_i),
        .num_vals_i(num_vals_i), .ready_o(ready_o), .done_o(done_o), .err_o(err_o),
        .buf_valid_o(buf_valid_o), .changed_o(changed_o), .converged_o(converged_o),
        .io_addr_o(io_addr_o), .io_din_i(io_din_i), .io_dout_o(io_dout_o), .io_we_o(io_we_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        io_din_i <= mem[io_addr_o];
        if (io_we_o) mem[io_addr_o] <= io_dout_o;
        if (poke_en) mem[poke_addr] <= poke_data;
    end

    always @(negedge clk_i) begin
        if (start_i && ready_o) begin
            we_cnt   = 0;
            max_addr = 0;
        end else begin
            if (io_we_o) we_cnt = we_cnt + 1;
            if (!ready_o && int'(io_addr_o) > max_addr) max_addr = int'(io_addr_o);
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic poke(input int addr, input logic [31:0] data);
        @(negedge clk_i);
        poke_en = 1'b1; poke_addr = 15'(addr); poke_data = data;
        @(posedge clk_i); #1;
        poke_en = 1'b0;
    endtask

    task automatic start_op(input logic [1:0] op, input logic [31:0] nv);
        @(negedge clk_i);
        start_i = 1'b1; op_i = op; num_vals_i = nv;
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int max, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk_i);
            cyc++;
        end while (!done_o && cyc < max);
        if (!done_o) cyc = -1;
    endtask

    task automatic test_reset();
        reset_ni = 1'b0;
        #12;
        n_cmp++; if ({ready_o, done_o, err_o, buf_valid_o, converged_o, io_we_o} !== 6'b100000) begin
            n_bad++; $display("[TB] FAIL reset_flags: got %b want 100000", {ready_o, done_o, err_o, buf_valid_o, converged_o, io_we_o}); end
        n_cmp++; if (io_addr_o !== 15'(BASE)) begin n_bad++; $display("[TB] FAIL reset_addr: got %0d want %0d", io_addr_o, BASE); end
        n_cmp++; if (io_dout_o !== 32'd0) begin n_bad++; $display("[TB] FAIL reset_dout: got %h want 0", io_dout_o); end
        n_cmp++; if (changed_o !== 13'd0) begin n_bad++; $display("[TB] FAIL reset_changed: got %0d want 0", changed_o); end
        @(negedge clk_i);
        reset_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_reject(input logic [1:0] op, input string name);
        start_op(op, 32'd10);
        @(negedge clk_i);
        n_cmp++; if ({err_o, ready_o, done_o} !== 3'b110) begin
            n_bad++; $display("[TB] FAIL %s_err_c1: err/ready/done got %b want 110", name, {err_o, ready_o, done_o}); end
        @(negedge clk_i);
        n_cmp++; if ({err_o, ready_o, we_cnt != 0} !== 3'b010) begin
            n_bad++; $display("[TB] FAIL %s_after: err/ready/wrote got %b want 010 (writes %0d)", name, {err_o, ready_o, we_cnt != 0}, we_cnt); end
    endtask

    task automatic test_load();
        poke(BASE + 0, 32'h03020100);
        poke(BASE + 1, 32'h07060504);
        poke(BASE + 2, 32'h00000908);
        start_op(2'd0, 32'd10);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk_i);
            n_cmp++; if ({ready_o, done_o, io_addr_o} !== {2'b00, 15'(BASE + c - 1)}) begin
                n_bad++; $display("[TB] FAIL load_addr_c%0d: ready/done/addr got %b/%b/%0d want 0/0/%0d", c, ready_o, done_o, io_addr_o, BASE + c - 1); end
        end
        @(negedge clk_i);
        n_cmp++; if ({ready_o, done_o} !== 2'b00) begin n_bad++; $display("[TB] FAIL load_c4: ready/done got %b want 00", {ready_o, done_o}); end
        @(negedge clk_i);
        n_cmp++; if ({ready_o, done_o, buf_valid_o} !== 3'b111) begin
            n_bad++; $display("[TB] FAIL load_done_c5: ready/done/valid got %b want 111", {ready_o, done_o, buf_valid_o}); end
    endtask

    task automatic test_store();
        logic [31:0] exp_w [3];
        exp_w[0] = 32'h03020100; exp_w[1] = 32'h07060504; exp_w[2] = 32'h00000908;
        for (int i = 0; i < 3; i++) poke(BASE + i, 32'h0);
        start_op(2'd1, 32'd10);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk_i);
            n_cmp++; if ({io_we_o, io_addr_o, io_dout_o} !== {1'b1, 15'(BASE + c - 1), exp_w[c-1]}) begin
                n_bad++; $display("[TB] FAIL store_c%0d: we/addr/dout got %b/%0d/%h want 1/%0d/%h", c, io_we_o, io_addr_o, io_dout_o, BASE + c - 1, exp_w[c-1]); end
        end
        @(negedge clk_i);
        n_cmp++; if ({done_o, ready_o, io_we_o} !== 3'b110) begin
            n_bad++; $display("[TB] FAIL store_done_c4: done/ready/we got %b want 110", {done_o, ready_o, io_we_o}); end
        @(negedge clk_i);
        n_cmp++; if (mem[BASE + 1] !== 32'h07060504) begin n_bad++; $display("[TB] FAIL store_mem1: got %h want 07060504", mem[BASE + 1]); end
    endtask

    task automatic test_empty(input logic [1:0] op, input string name);
        start_op(op, 32'd0);
        @(negedge clk_i);
        n_cmp++; if ({done_o, ready_o, err_o, buf_valid_o} !== 4'b1101) begin
            n_bad++; $display("[TB] FAIL %s_empty: done/ready/err/valid got %b want 1101", name, {done_o, ready_o, err_o, buf_valid_o}); end
        @(negedge clk_i);
        n_cmp++; if ({done_o, we_cnt, max_addr} !== {1'b0, 32'd0, 32'd0}) begin
            n_bad++; $display("[TB] FAIL %s_empty_access: done %b writes %0d maxaddr %0d want 0/0/0", name, done_o, we_cnt, max_addr); end
    endtask

`ifdef ASSIGN_BUF_CMP_EN
    task automatic test_compare();
        int cyc;
        test_empty(2'd2, "cmp");
        n_cmp++; if ({changed_o, converged_o} !== {13'd0, 1'b1}) begin
            n_bad++; $display("[TB] FAIL cmp_empty_flags: changed %0d conv %b want 0/1", changed_o, converged_o); end
        poke(BASE + 1, 32'h07060A04);
        poke(BASE + 2, 32'hFFFF0908);
        start_op(2'd2, 32'd10);
        wait_done(20, cyc);
        n_cmp++; if (cyc !== 5) begin n_bad++; $display("[TB] FAIL cmp_latency: done at cycle %0d want 5", cyc); end
        n_cmp++; if ({changed_o, converged_o, buf_valid_o} !== {13'd1, 1'b0, 1'b1}) begin
            n_bad++; $display("[TB] FAIL cmp_changed: changed %0d conv %b valid %b want 1/0/1", changed_o, converged_o, buf_valid_o); end
        test_store();
        start_op(2'd2, 32'd10);
        wait_done(20, cyc);
        n_cmp++; if ({changed_o, converged_o} !== {13'd0, 1'b1}) begin
            n_bad++; $display("[TB] FAIL cmp_converged: changed %0d conv %b want 0/1", changed_o, converged_o); end
    endtask
`else
    task automatic test_compare();
        test_reject(2'd2, "cmp_off");
        n_cmp++; if ({changed_o, converged_o} !== 14'd0) begin
            n_bad++; $display("[TB] FAIL cmp_off_flags: changed %0d conv %b want 0/0", changed_o, converged_o); end
    endtask
`endif

    task automatic test_clamp();
        int cyc;
        start_op(2'd0, 32'd5000);
        wait_done(1100, cyc);
        n_cmp++; if (cyc !== 1026) begin n_bad++; $display("[TB] FAIL clamp_load_latency: done at %0d want 1026", cyc); end
        n_cmp++; if (max_addr !== BASE + 1023) begin n_bad++; $display("[TB] FAIL clamp_load_addr: max %0d want %0d", max_addr, BASE + 1023); end
        start_op(2'd1, 32'd5000);
        wait_done(1100, cyc);
        n_cmp++; if (cyc !== 1025) begin n_bad++; $display("[TB] FAIL clamp_store_latency: done at %0d want 1025", cyc); end
        n_cmp++; if (we_cnt !== 1024) begin n_bad++; $display("[TB] FAIL clamp_store_writes: got %0d want 1024", we_cnt); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk_i);
        start_i = 1'b1; op_i = 2'd0; num_vals_i = 32'd10;
        @(negedge clk_i);
        n_cmp++; if ({ready_o, buf_valid_o} !== 2'b00) begin
            n_bad++; $display("[TB] FAIL mid_c1: ready/valid got %b want 00", {ready_o, buf_valid_o}); end
        @(negedge clk_i);
        n_cmp++; if (io_addr_o !== 15'(BASE + 1)) begin n_bad++; $display("[TB] FAIL mid_c2_addr: got %0d want %0d", io_addr_o, BASE + 1); end
        @(posedge clk_i); #1;
        reset_ni = 1'b0;
        #1;
        n_cmp++; if ({ready_o, done_o, err_o, buf_valid_o, io_we_o, io_addr_o} !== {5'b10000, 15'(BASE)}) begin
            n_bad++; $display("[TB] FAIL mid_reset: ready/done/err/valid/we got %b addr %0d want 10000/%0d", {ready_o, done_o, err_o, buf_valid_o, io_we_o}, io_addr_o, BASE); end
        @(negedge clk_i);
        start_i = 1'b0;
        reset_ni = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        n_cmp++; if ({ready_o, done_o, buf_valid_o} !== 3'b100) begin
            n_bad++; $display("[TB] FAIL mid_after: ready/done/valid got %b want 100", {ready_o, done_o, buf_valid_o}); end
        test_reject(2'd1, "mid_store");
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_reject(2'd1, "store_rst");
        test_reject(2'd2, "cmp_rst");
        test_reject(2'd3, "rsvd");
        test_load();
        test_store();
        test_empty(2'd0, "load");
        test_empty(2'd1, "store");
        test_compare();
        test_clamp();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
